// File: rtl/cpu_defs.sv
// Shared fetch-path definitions: default widths, fetch FSM encodings and PC step.
package cpu_defs;
   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instr} entries with push, pop and flush; flush wins over both.
module fetch_fifo #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);
   logic [DEPTH-1:0][ADDR_W-1:0]  pc_mem;
   logic [DEPTH-1:0][INSTR_W-1:0] instr_mem;
   logic [PTR_W-1:0]              rd_ptr, wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset; the head is only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];
   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one-outstanding req/ack fetch into a small FIFO, valid/ready to the IR.
// Optional IFETCH_BYPASS_EN forwards an ack straight to the IR when the FIFO is empty.
module instr_fetch_unit #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = cpu_defs::ADDR_W,
   parameter int INSTR_W = cpu_defs::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [INSTR_W-1:0] ir_data,
   output logic [ADDR_W-1:0]  ir_pc
);
   import cpu_defs::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_state_t       state;
   logic [ADDR_W-1:0]  fetch_pc, rpc, pc_inc;
   logic [ADDR_W-1:0]  head_pc;
   logic [INSTR_W-1:0] head_instr;
   logic [CNT_W-1:0]   count, cnt_n;
   logic               full, empty, ack_push, byp, fifo_push, fifo_pop;

   assign rpc      = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc   = fetch_pc + ADDR_W'(PC_INC);
   assign ack_push = (state == REQ) && mem_ack && !redirect;

`ifdef IFETCH_BYPASS_EN
   assign byp = ack_push && empty;
`else
   assign byp = 1'b0;
`endif

   // A bypassed entry taken by the consumer never touches the FIFO.
   assign fifo_push = ack_push && !(byp && ir_ready);
   assign fifo_pop  = !empty && ir_ready && !redirect;
   assign cnt_n     = count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   fetch_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (fifo_push),
      .push_pc    (fetch_pc),
      .push_instr (mem_rdata),
      .pop        (fifo_pop),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   // mem_addr follows fetch_pc except while a redirected request is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
      end else begin
         unique case (state)
            IDLE: begin
               if (redirect) begin
                  fetch_pc <= rpc;
                  mem_addr <= rpc;
               end else if (!full) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (redirect) begin
                  fetch_pc <= rpc;
                  if (mem_ack) begin
                     state    <= IDLE;
                     mem_addr <= rpc;
                  end else begin
                     state <= DROP;
                  end
               end else if (mem_ack) begin
                  fetch_pc <= pc_inc;
                  mem_addr <= pc_inc;
                  if (cnt_n >= DEPTH_C) state <= IDLE;
               end
            end
            DROP: begin
               if (redirect) fetch_pc <= rpc;
               if (mem_ack) begin
                  state    <= IDLE;
                  mem_addr <= redirect ? rpc : fetch_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req  = (state != IDLE);
   assign ir_valid = !empty || byp;
   assign ir_data  = !empty ? head_instr : (byp ? mem_rdata : '0);
   assign ir_pc    = !empty ? head_pc    : (byp ? fetch_pc  : '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expectations adapt to the IFETCH_BYPASS_EN build.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic [31:0] ir_data;
   logic [63:0] ir_pc;

   int          tests = 0;
   int          fails = 0;
   bit          ovr_en = 1'b0;
   logic [31:0] ovr_data = '0;

   instr_fetch_unit #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return {8'hC0, a[23:0]};
   endfunction

   // ack: 0 none, 1 forced, 2 answer whatever request is pending this cycle
   task automatic step(input int ack, input bit rdy, input bit redir, input logic [63:0] rpc);
      @(negedge clk);
      mem_ack     = (ack == 2) ? mem_req : (ack == 1);
      mem_rdata   = ovr_en ? ovr_data : instr_of(mem_addr);
      ir_ready    = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; mem_ack = 1'b0; ir_ready = 1'b0; redirect = 1'b0; ovr_en = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 64'h0 || ir_pc !== 64'h0 || ir_data !== 32'h0) begin
         fails++;
         $display("FAIL %s_reset: req=%b valid=%b addr=%h pc=%h data=%h, want all 0", tag, mem_req, ir_valid, mem_addr, ir_pc, ir_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset("power_on");
   endtask

   task automatic test_reset_mid_req;
      do_reset("pre_mid");
      step(0, 0, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1) begin
         fails++;
         $display("FAIL mid_req_setup: mem_req=%b want 1", mem_req);
      end
      do_reset("mid_req");
   endtask

   task automatic test_stream;
      logic [63:0] exp_pc;
      bit          exp_v;
      do_reset("stream");
      for (int i = 0; i < 8; i++) begin
         step(2, 1, 0, 64'h0);
`ifdef IFETCH_BYPASS_EN
         exp_v = 1'b1; exp_pc = 64'(4 * i);
`else
         exp_v = (i > 0); exp_pc = 64'(4 * (i - 1));
`endif
         tests++;
         if (mem_req !== 1'b1 || mem_addr !== 64'(4 * i)) begin
            fails++;
            $display("FAIL stream_addr[%0d]: req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, 4 * i);
         end
         tests++;
         if (ir_valid !== exp_v || (exp_v && (ir_pc !== exp_pc || ir_data !== instr_of(exp_pc)))) begin
            fails++;
            $display("FAIL stream_ir[%0d]: valid=%b pc=%h data=%h want valid=%b pc=%h", i, ir_valid, ir_pc, ir_data, exp_v, exp_pc);
         end
      end
   endtask

   task automatic test_backpressure;
      int acks;
      do_reset("bp");
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         step(2, 0, 0, 64'h0);
         if (mem_ack) acks++;
      end
      tests++;
      if (acks != 4 || mem_req !== 1'b0 || dut.u_fifo.count !== 3'd4) begin
         fails++;
         $display("FAIL bp_full: acks=%0d req=%b count=%0d want 4/0/4", acks, mem_req, dut.u_fifo.count);
      end
      tests++;
      if (ir_valid !== 1'b1 || ir_pc !== 64'h0) begin
         fails++;
         $display("FAIL bp_head: valid=%b pc=%h want 1/0", ir_valid, ir_pc);
      end
      step(0, 1, 0, 64'h0);
      step(0, 0, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b0 || ir_pc !== 64'h4 || dut.u_fifo.count !== 3'd3) begin
         fails++;
         $display("FAIL bp_pop: req=%b pc=%h count=%0d want 0/4/3", mem_req, ir_pc, dut.u_fifo.count);
      end
      step(2, 0, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin
         fails++;
         $display("FAIL bp_resume: req=%b addr=%h want 1/10", mem_req, mem_addr);
      end
   endtask

   task automatic test_redirect_drop;
      do_reset("drop");
      step(0, 1, 1, 64'h103);
      for (int i = 0; i < 3; i++) begin
         step((i == 2) ? 1 : 0, 1, 0, 64'h0);
         tests++;
         if (mem_req !== 1'b1 || mem_addr !== 64'h0 || ir_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_hold[%0d]: req=%b addr=%h valid=%b want 1/0/0", i, mem_req, mem_addr, ir_valid);
         end
      end
      step(0, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 64'h100) begin
         fails++;
         $display("FAIL drop_discard: req=%b valid=%b addr=%h want 0/0/100", mem_req, ir_valid, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h100) begin
         fails++;
         $display("FAIL drop_restart: req=%b addr=%h want 1/100", mem_req, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
`ifdef IFETCH_BYPASS_EN
      if (ir_valid !== 1'b1 || ir_pc !== 64'h104) begin
`else
      if (ir_valid !== 1'b1 || ir_pc !== 64'h100) begin
`endif
         fails++;
         $display("FAIL drop_deliver: valid=%b pc=%h", ir_valid, ir_pc);
      end
   endtask

   task automatic test_redirect_ack_pop;
      do_reset("rap");
      step(2, 0, 0, 64'h0);
      step(2, 0, 0, 64'h0);
      step(1, 1, 1, 64'h200);
      tests++;
      if (dut.u_fifo.count !== 3'd2 || ir_pc !== 64'h0 || mem_addr !== 64'h8) begin
         fails++;
         $display("FAIL rap_setup: count=%0d pc=%h addr=%h want 2/0/8", dut.u_fifo.count, ir_pc, mem_addr);
      end
      step(0, 1, 0, 64'h0);
      tests++;
      if (ir_valid !== 1'b0 || dut.u_fifo.count !== 3'd0 || mem_req !== 1'b0 || mem_addr !== 64'h200) begin
         fails++;
         $display("FAIL rap_flush: valid=%b count=%0d req=%b addr=%h want 0/0/0/200", ir_valid, dut.u_fifo.count, mem_req, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h200) begin
         fails++;
         $display("FAIL rap_restart: req=%b addr=%h want 1/200", mem_req, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
`ifdef IFETCH_BYPASS_EN
      if (ir_valid !== 1'b1 || ir_pc !== 64'h204) begin
`else
      if (ir_valid !== 1'b1 || ir_pc !== 64'h200) begin
`endif
         fails++;
         $display("FAIL rap_deliver: valid=%b pc=%h", ir_valid, ir_pc);
      end
   endtask

   task automatic test_pc_wrap;
      do_reset("wrap");
      step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      step(0, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         fails++;
         $display("FAIL wrap_redirect: req=%b valid=%b addr=%h want 0/0/FFFFFFFFFFFFFFFC", mem_req, ir_valid, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         fails++;
         $display("FAIL wrap_first: req=%b addr=%h", mem_req, mem_addr);
      end
      step(2, 1, 0, 64'h0);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
         fails++;
         $display("FAIL wrap_second: req=%b addr=%h want 1/0", mem_req, mem_addr);
      end
      tests++;
`ifdef IFETCH_BYPASS_EN
      if (ir_valid !== 1'b1 || ir_pc !== 64'h0 || $isunknown(ir_data)) begin
`else
      if (ir_valid !== 1'b1 || ir_pc !== 64'hFFFF_FFFF_FFFF_FFFC || $isunknown(ir_data)) begin
`endif
         fails++;
         $display("FAIL wrap_ir: valid=%b pc=%h data=%h", ir_valid, ir_pc, ir_data);
      end
   endtask

   task automatic test_bypass;
      do_reset("byp");
      ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
      step(1, 1, 0, 64'h0);
      tests++;
`ifdef IFETCH_BYPASS_EN
      if (ir_valid !== 1'b1 || ir_data !== 32'hDEAD_BEEF || ir_pc !== 64'h0) begin
`else
      if (ir_valid !== 1'b0) begin
`endif
         fails++;
         $display("FAIL byp_ack_cycle: valid=%b data=%h pc=%h", ir_valid, ir_data, ir_pc);
      end
      ovr_en = 1'b0;
      step(0, 1, 0, 64'h0);
      tests++;
`ifdef IFETCH_BYPASS_EN
      if (ir_valid !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
`else
      if (ir_valid !== 1'b1 || ir_data !== 32'hDEAD_BEEF || dut.u_fifo.count !== 3'd1) begin
`endif
         fails++;
         $display("FAIL byp_next_cycle: valid=%b data=%h count=%0d", ir_valid, ir_data, dut.u_fifo.count);
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid_req;
      test_stream;
      test_backpressure;
      test_redirect_drop;
      test_redirect_ack_pop;
      test_pc_wrap;
      test_bypass;
      do_reset("final");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
